// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock with a
// registered carry between slices, plus accumulate mode and carry/overflow flags.
module chunked_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             acc,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  // Handshake: start is taken only while busy=0 (including the done cycle);
  // done pulses for one cycle on the edge that commits sum/cout/ovf.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] op_a, op_b, res, res_nxt;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
  logic             chunk_c;
  logic             msb_cin;
  logic             last;

  always_comb begin
    chunk_a = op_a[int'(idx)*CHUNK +: CHUNK];
    chunk_b = op_b[int'(idx)*CHUNK +: CHUNK];
    {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
    // Carry into the top bit recovered from that bit's sum: s = a ^ b ^ c_in.
    msb_cin = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1];
    res_nxt = res;
    res_nxt[int'(idx)*CHUNK +: CHUNK] = chunk_s;
    last = (idx == LAST_IDX);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= acc ? sum : a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
          end
        end
        CALC: begin
          res   <= res_nxt;
          carry <= chunk_c;
          if (last) begin
            idx  <= '0;
            sum  <= res_nxt;
            cout <= chunk_c;
            ovf  <= chunk_c ^ msb_cin;
            done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == CALC);
  assign dbg_state = state;

endmodule

// File: tb/tb_chunked_adder.sv
// Randomised and directed bench for chunked_adder: an 8-bit/4-bit-chunk instance
// and a 4-bit/1-bit-chunk instance swept exhaustively, both against an arithmetic model.
module tb_chunked_adder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       start8, sub8, acc8, cin8;
  logic [7:0] a8, b8, sum8;
  logic       busy8, done8, cout8, ovf8, dbg8;

  logic       start4, sub4, acc4, cin4;
  logic [3:0] a4, b4, sum4;
  logic       busy4, done4, cout4, ovf4, dbg4;

  chunked_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .acc(acc8), .cin(cin8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .dbg_state(dbg8)
  );

  chunked_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sub(sub4), .acc(acc4), .cin(cin4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4),
    .dbg_state(dbg4)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [9:0] exp_q[$];
  logic [7:0] model_sum;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Two's-complement arithmetic model: returns {ovf, cout, sum[w-1:0]}.
  function automatic int model(int w, int x, int y, int c, int s);
    int mask, yy, t, sm, co, sx, sy, ss, v;
    mask = (1 << w) - 1;
    yy   = s ? ((~y) & mask) : (y & mask);
    t    = (x & mask) + yy + (s ? 1 : c);
    sm   = t & mask;
    co   = (t >> w) & 1;
    sx   = (x >> (w - 1)) & 1;
    sy   = (yy >> (w - 1)) & 1;
    ss   = (sm >> (w - 1)) & 1;
    v    = (sx == sy && ss != sx) ? 1 : 0;
    return (v << (w + 1)) | (co << w) | sm;
  endfunction

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge after the accepting edge E0.
  task automatic launch8(input logic [7:0] ia, input logic [7:0] ib,
                         input logic icin, input logic isub, input logic iacc);
    int r;
    r = model(8, iacc ? int'(model_sum) : int'(ia), ib, icin, isub);
    exp_q.push_back(r[9:0]);
    model_sum = r[7:0];
    a8 = ia; b8 = ib; cin8 = icin; sub8 = isub; acc8 = iacc; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Waits for done, optionally poking start with junk while busy.
  task automatic wait8(input bit poke);
    int         lat, busy_n;
    logic [9:0] e;
    lat    = 0;
    busy_n = busy8;
    while (!done8 && lat < 16) begin
      if (poke && lat == 0) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        sub8 = 1'($urandom); acc8 = 1'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      start8 = 1'b0;
      lat++;
      busy_n += busy8;
    end
    check("done_seen8", done8, 1);
    check("latency8", lat, 2);
    check("busy_cycles8", busy_n, 2);
    if (exp_q.size() == 0) begin
      check("exp_q_empty8", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("sum8", sum8, e[7:0]);
      check("cout8", cout8, e[8]);
      check("ovf8", ovf8, e[9]);
    end
    if (poke) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("no_extra_done8", done8, 0);
        check("sum_held8", sum8, model_sum);
      end
    end
  endtask

  task automatic op4(input int x, input int y, input int c, input int s);
    int lat, busy_n, r;
    a4 = 4'(x); b4 = 4'(y); cin4 = 1'(c); sub4 = 1'(s); acc4 = 1'b0; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat    = 0;
    busy_n = busy4;
    while (!done4 && lat < 16) begin
      @(negedge clk);
      lat++;
      busy_n += busy4;
    end
    r = model(4, x, y, c, s);
    check("latency4", lat, 4);
    check("busy_cycles4", busy_n, 4);
    check("sum4", sum4, r & 15);
    check("cout4", cout4, (r >> 4) & 1);
    check("ovf4", ovf4, (r >> 5) & 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; acc8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; sub4 = 1'b0; acc4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
    model_sum = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_sum8", sum8, 0);
    check("rst_cout8", cout8, 0);
    check("rst_ovf8", ovf8, 0);
    check("rst_busy4", busy4, 0);

    // Directed add/sub cases
    launch8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0); wait8(0);
    check("dir_0f_plus_01", sum8, 8'h10);
    @(negedge clk);
    launch8(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0); wait8(0);
    @(negedge clk);
    launch8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0); wait8(0);
    check("dir_7f_ovf", ovf8, 1);
    @(negedge clk);
    launch8(8'h7F, 8'hFF, 1'b0, 1'b1, 1'b0); wait8(0);
    @(negedge clk);
    launch8(8'h05, 8'h03, 1'b1, 1'b1, 1'b0); wait8(0);
    check("dir_sub_sum", sum8, 8'h02);

    // Accumulate, back-to-back on the done cycle
    @(negedge clk);
    launch8(8'h05, 8'h03, 1'b0, 1'b0, 1'b0); wait8(0);
    launch8(8'hAA, 8'h10, 1'b0, 1'b0, 1'b1); wait8(0);
    check("acc_sum", sum8, 8'h18);

    // start while busy is ignored
    @(negedge clk);
    launch8(8'h21, 8'h12, 1'b0, 1'b0, 1'b0); wait8(1);

    // Reset on the first CALC cycle aborts
    @(negedge clk);
    launch8(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_back());
    model_sum = '0;
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_sum", sum8, 0);
    check("abort_cout", cout8, 0);
    check("abort_ovf", ovf8, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", done8, 0);
    end
    launch8(8'h12, 8'h34, 1'b1, 1'b0, 1'b0); wait8(0);

    // Random operations
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) @(negedge clk);
      launch8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 1)));
      wait8($urandom_range(0, 7) == 0);
    end

    // Exhaustive sweep on the 1-bit-chunk instance
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++)
            op4(x, y, c, s);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/chunked_adder.md
Name: chunked_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the 4-bit combinational full-adder chain.
- Processes a WIDTH-bit operation CHUNK bits per clock and ripples the carry between chunks through a register.
- Adds subtract and accumulate modes, carry-out and signed-overflow flags, and a start/busy/done handshake.
- Used wherever wide arithmetic must meet timing without a full-width carry chain.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 4, bits processed per cycle. NCHUNK = WIDTH/CHUNK. CHUNK = WIDTH is legal and gives 1-cycle operation.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new operation. Sampled only when busy=0.
- sub  input  1  0: A+B+cin. 1: A+~B+1 (A-B), cin ignored.
- acc  input  1  1: operand A is replaced by the current sum output (accumulate).
- cin  input  1  carry-in for add mode.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when a result is committed.
- sum  output  WIDTH  result, held until the next completed operation.
- cout  output  1  carry out of MSB (sub mode: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: busy=0, done=0, sum=0, cout=0, ovf=0, state IDLE, chunk index 0, internal carry 0. Reset has priority over all other inputs.
- States:
  - IDLE: on start=1 at an edge, latch the operands. A ← (acc ? sum : a). B ← (sub ? ~b : b). Carry ← (sub ? 1 : cin). Index ← 0. Go to CALC with busy=1.
  - CALC: each edge adds chunk[index] of A, B and the carry. Write the CHUNK-bit result into the internal result register and register the chunk carry-out. Index increments.
  - On the edge that processes chunk NCHUNK-1:
    - Copy the full result to sum.
    - Set cout to the final carry.
    - Set ovf to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
    - busy←0, done←1, return to IDLE.
- Latency: start sampled at edge E0. Result, flags and done are visible after edge E(NCHUNK), i.e. NCHUNK cycles later. busy is high for exactly NCHUNK cycles.
- done is high for exactly one cycle. start may be high in the same cycle as done. That start is accepted and gives back-to-back operation with no idle cycle. With acc=1, it uses the just-committed sum.
- start while busy=1 is ignored. Operand changes during CALC have no effect, because the operands were latched.
- sum, cout and ovf change only on commit. Partial chunk results are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH. The carry chain is exactly that of a WIDTH-bit ripple adder.
- Reset during CALC aborts the operation: no done pulse, outputs cleared to 0.
- When NCHUNK=1, CALC lasts one cycle: start at E0, done after E1.

Test Plan:
- WIDTH=8, CHUNK=4. a=0x0F, b=0x01, cin=0, start → done exactly 2 cycles after start, sum=0x10, cout=0, ovf=0. busy high for 2 cycles.
- a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1, ovf=0. a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1.
- sub=1, a=0x7F, b=0xFF → sum=0x80, cout=0, ovf=1. sub=1, a=0x05, b=0x03, cin=1 → sum=0x02, cout=1, ovf=0 (cin ignored).
- Accumulate:
  - Step 1: a=0x05, b=0x03 → 0x08.
  - Step 2: start held high on the done cycle with acc=1, b=0x10, a=0xAA → sum=0x18 after 2 more cycles. No idle cycle between operations.
- Boundary:
  - start pulsed again mid-CALC with different operands → ignored, first result unchanged.
  - reset asserted on the 1st CALC cycle → busy=0, no done, sum=0. A subsequent start works normally.
- Sweep with WIDTH=4, CHUNK=1: all a, b in 0..15, cin in {0,1}, sub in {0,1} → sum/cout/ovf match a golden 4-bit model. Latency is 4 cycles for every vector.
